// File: rtl/uart_sample_packer_pkg.sv
// Shared types and helpers for the UART-to-PCM sample packer.
// Holds the frame-position enum, the byte-lane map and the timeout sizing function.
package uart_sample_packer_pkg;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } state_e;

  // Little-endian L then R: {L_hi, L_lo, R_hi, R_lo} = {B1, B0, B3, B2}
  localparam int LANE_B0_LSB = 16;
  localparam int LANE_B1_LSB = 24;
  localparam int LANE_B2_LSB = 0;
  localparam int LANE_B3_LSB = 8;

  function automatic int lane_lsb(input state_e s);
    case (s)
      B0:      return LANE_B0_LSB;
      B1:      return LANE_B1_LSB;
      B2:      return LANE_B2_LSB;
      default: return LANE_B3_LSB;
    endcase
  endfunction

  function automatic int timeout_cycles(input longint clk_hz, input longint baud,
                                        input longint bytes);
    return int'((bytes * 64'd10 * clk_hz) / baud);
  endfunction

endpackage

// File: rtl/uart_sample_packer_idle_timer.sv
// Saturating idle counter; pulses expire on the cycle the count reaches TERMINAL.
// Only instantiated when PACKER_RESYNC_TIMEOUT_EN is defined.
module idle_timer #(
  parameter int TERMINAL = 160
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TERMINAL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TERMINAL - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TERMINAL);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A clear in the expiry cycle suppresses the pulse so a late byte still wins.
  assign expire = enable && !clear && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only; the comb block above
  // computes the next value with blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_sample_packer.sv
// Packs UART bytes into 32-bit {L,R} PCM words for the sample FIFO, with flow control.
// Optional macro PACKER_RESYNC_TIMEOUT_EN enables idle-gap frame resynchronisation.
module uart_sample_packer
  import uart_sample_packer_pkg::*;
#(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int BAUDRATE      = 3_000_000,
  parameter int TIMEOUT_BYTES = 4,
  parameter int FIFO_BITS     = 32,
  parameter int CNT_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 received,
  input  logic                 fifo_full,
  input  logic                 fifo_almost_em,
  input  logic                 fifo_almost_fu,
  output logic                 wr_en,
  output logic [FIFO_BITS-1:0] wr_data,
  output logic                 cts,
  output logic                 dsr,
  output logic [CNT_BITS-1:0]  drop_count,
  output logic [CNT_BITS-1:0]  resync_count,
  output logic [1:0]           frame_pos
);

  localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQ, BAUDRATE, TIMEOUT_BYTES);

  if (FIFO_BITS != 32) begin : g_bad_width
    $error("uart_sample_packer: FIFO_BITS must be 32");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("uart_sample_packer: timeout shorter than 2 cycles");
  end

  state_e                state_q, state_d;
  logic [FIFO_BITS-1:0]  wr_data_q, wr_data_d;
  logic                  commit_q, commit_d;
  logic [CNT_BITS-1:0]   drop_count_q, drop_count_d;
  logic                  cts_q, dsr_q;
  logic                  timeout_expire;

`ifdef PACKER_RESYNC_TIMEOUT_EN
  logic [CNT_BITS-1:0] resync_count_q, resync_count_d;

  idle_timer #(.TERMINAL(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (received),
    .enable  (state_q != B0),
    .expire  (timeout_expire)
  );

  always_comb begin
    resync_count_d = resync_count_q;
    if (timeout_expire && resync_count_q != '1) resync_count_d = resync_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) resync_count_q <= '0;
    else          resync_count_q <= resync_count_d;
  end

  assign resync_count = resync_count_q;
`else
  assign timeout_expire = 1'b0;
  assign resync_count   = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= B0;
    else          state_q <= state_d;
  end

  // Next state: a byte always advances; the timeout only fires without a byte.
  always_comb begin
    state_d = state_q;
    if (received) begin
      case (state_q)
        B0:      state_d = B1;
        B1:      state_d = B2;
        B2:      state_d = B3;
        default: state_d = B0;
      endcase
    end else if (timeout_expire) begin
      state_d = B0;
    end
  end

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    wr_data_d    = wr_data_q;
    commit_d     = 1'b0;
    drop_count_d = drop_count_q;
    if (received) begin
      wr_data_d[lane_lsb(state_q) +: 8] = rx_data;
      commit_d = (state_q == B3);
    end
    if (commit_q && fifo_full && drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_data_q    <= '0;
      commit_q     <= 1'b0;
      drop_count_q <= '0;
      cts_q        <= 1'b1;
      dsr_q        <= 1'b1;
    end else begin
      wr_data_q    <= wr_data_d;
      commit_q     <= commit_d;
      drop_count_q <= drop_count_d;
      cts_q        <= ~fifo_almost_em;
      dsr_q        <= ~fifo_almost_fu;
    end
  end

  // Outputs: the write strobe looks at fifo_full in the commit cycle itself.
  always_comb begin
    wr_en      = commit_q && !fifo_full;
    wr_data    = wr_data_q;
    cts        = cts_q;
    dsr        = dsr_q;
    drop_count = drop_count_q;
    frame_pos  = state_q;
  end

endmodule
